// File: rtl/reg_shift_n.sv
// Parametrised datapath register with hold/load/shift/rotate/arithmetic-shift modes,
// a multi-cycle "shift by N" sequencer with busy/done status, and a serial in/out path.
module reg_shift_n #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] Reg_In,
    input  logic             ser_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] Reg_Out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] AMT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q,   reg_d;
    logic             ser_q,   ser_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [2:0]       mode_q,  mode_d;
    logic [WIDTH:0]   step_s;
    logic [2:0]       step_op_s;

    // One shift/rotate step; result is {bit shifted out, new register value}.
    function automatic logic [WIDTH:0] step_f(input logic [2:0] op,
                                              input logic [WIDTH-1:0] val,
                                              input logic sin);
        logic [WIDTH:0] r;
        case (op)
            MODE_SHL: r = {val[WIDTH-1], val[WIDTH-2:0], sin};
            MODE_SHR: r = {val[0], sin, val[WIDTH-1:1]};
            MODE_ROL: r = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
            MODE_ROR: r = {val[0], val[0], val[WIDTH-1:1]};
            MODE_ASR: r = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            default:  r = {1'b0, val};
        endcase
        return r;
    endfunction

    function automatic logic is_shift_f(input logic [2:0] op);
        logic r;
        case (op)
            MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
            default:                                          r = 1'b0;
        endcase
        return r;
    endfunction

    // Select which mode drives the step: latched mode while running, live mode otherwise.
    always_comb begin
        if (state_q == ST_RUN) begin
            step_op_s = mode_q;
        end else begin
            step_op_s = mode;
        end
        step_s = step_f(step_op_s, reg_q, ser_in);
    end

    // Next-state and datapath decision for the sequencer and register.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        ser_d   = ser_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        mode_d  = mode_q;

        if (!EN) begin
            done_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            reg_d = step_s[WIDTH-1:0];
            ser_d = step_s[WIDTH];
            cnt_d = cnt_q - AMT_ONE;
            // A zero count here is unreachable; treat it as finished rather than wrapping.
            if (cnt_q <= AMT_ONE) begin
                cnt_d   = AMT_ZERO;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                done_d = 1'b0;
            end
        end else if (start) begin
            if (is_shift_f(mode) && (amt != AMT_ZERO)) begin
                reg_d  = step_s[WIDTH-1:0];
                ser_d  = step_s[WIDTH];
                cnt_d  = amt - AMT_ONE;
                mode_d = mode;
                if (amt == AMT_ONE) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end else begin
                if (mode == MODE_LOAD) begin
                    reg_d = Reg_In;
                end else begin
                    reg_d = reg_q;
                end
                done_d = 1'b1;
            end
        end else begin
            case (mode)
                MODE_LOAD: reg_d = Reg_In;
                MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: begin
                    reg_d = step_s[WIDTH-1:0];
                    ser_d = step_s[WIDTH];
                end
                MODE_HOLD: reg_d = reg_q;
                default:   reg_d = reg_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= ST_IDLE;
            reg_q   <= {WIDTH{1'b0}};
            ser_q   <= 1'b0;
            cnt_q   <= AMT_ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= MODE_HOLD;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            ser_q   <= ser_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
        end
    end

    assign Reg_Out = reg_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: doc/reg_shift_n.md
Name: reg_shift_n

Overview:
- Parametrised successor to the fixed 8-bit enable register.
- Generalised to WIDTH bits, with a mode select: hold, parallel load, logical shift, rotate, arithmetic shift.
- Adds a multi-cycle "shift by N" sequencer with busy/done status and a serial in/out path.
- Intended as the common datapath register for serial links and shift-and-add arithmetic in the library.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- AMT_W, 3, width of shift-amount input; must satisfy 2**AMT_W >= WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- res  in  1  synchronous reset, active-low.
- EN  in  1  global enable; 0 freezes all state, including an in-progress sequence.
- mode  in  3  operation select; encoding under Behaviour.
- Reg_In  in  WIDTH  parallel load data.
- ser_in  in  1  serial fill bit for SHL/SHR.
- amt  in  AMT_W  shift count for a sequenced operation.
- start  in  1  launches a sequenced shift of amt steps.
- Reg_Out  out  WIDTH  register contents.
- ser_out  out  1  registered copy of the last bit shifted or rotated out.
- busy  out  1  high while a sequence runs.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Reset: on a rising edge with res=0:
  - Reg_Out=0, ser_out=0, busy=0, done=0, state=IDLE, step counter=0.
  - Reset has priority over EN and start, and aborts a running sequence with no done pulse.
- Mode encoding:
  - 000 HOLD.
  - 001 LOAD: Reg_Out<=Reg_In.
  - 010 SHL: Reg_Out<={Reg_Out[W-2:0],ser_in}; ser_out<=Reg_Out[W-1].
  - 011 SHR: Reg_Out<={ser_in,Reg_Out[W-1:1]}; ser_out<=Reg_Out[0].
  - 100 ROL, 101 ROR: rotate by one; ser_out<=the bit rotated.
  - 110 ASR: MSB replicated; ser_out<=Reg_Out[0].
  - 111 reserved, behaves as HOLD.
- ser_out changes only on shift/rotate steps; otherwise it holds.
- EN=0: no state changes at all (Reg_Out, ser_out, counter, state, busy hold); done is driven 0.
- FSM states: IDLE, RUN.
- IDLE, EN=1, start=0: the selected mode executes once per cycle, 1-cycle latency.
- IDLE, EN=1, start=1, mode in SHL..ASR, amt>0:
  - The first step executes in the same edge; counter<=amt-1; busy<=1 if amt>1.
  - If amt=1: stays IDLE, done=1 next cycle.
- IDLE, start=1, amt=0, or start=1 with HOLD/LOAD/111:
  - A single ordinary mode cycle executes (HOLD/LOAD per mode; amt=0 with shift modes leaves Reg_Out unchanged).
  - done pulses 1 for one cycle; busy stays 0.
- RUN, each enabled cycle: performs one step of the mode latched at start, using the ser_in live on that cycle; counter decrements.
  - When counter reaches 0 after its step: go IDLE, busy<=0, done<=1 for exactly one cycle.
  - mode, Reg_In, amt and start are ignored in RUN; start in RUN is dropped, not queued.
- A sequence of amt=k completes k steps over k enabled cycles. done is asserted on the edge after the last step; Reg_Out already holds the final value when done=1.
- Back-to-back: start is accepted in the cycle done=1 (state is IDLE).

Test Plan:
- res=0 for 2 edges with Reg_In=8'hFF, mode=LOAD -> Reg_Out=8'h00, busy=0, done=0, ser_out=0.
- res=1, EN=1, LOAD 8'h77 -> Reg_Out=8'h77 next edge. EN=0 with mode=SHL for 3 edges -> Reg_Out stays 8'h77.
- Reg_Out=8'h81, single-cycle cases:
  - ROL -> 8'h03, ser_out=1.
  - ROR from 8'h81 -> 8'hC0, ser_out=1.
  - ASR from 8'h80 -> 8'hC0, ser_out=0.
  - SHR with ser_in=1 from 8'h02 -> 8'h81, ser_out=0.
- Reg_Out=8'h01, start=1, mode=SHL, amt=3, ser_in=0:
  - busy high for cycles 1-2, Reg_Out steps 02,04,08.
  - done=1 for one cycle after the third step; changes to mode/start during RUN have no effect.
- During an amt=5 ROL sequence:
  - EN=0 for 2 cycles -> counter and Reg_Out freeze, total 5 enabled steps.
  - res=0 mid-sequence -> Reg_Out=0, busy=0, and no done pulse.
- start with amt=0 (SHL) and with mode=LOAD -> done pulses once; Reg_Out unchanged / loaded respectively; busy never asserts.
